// File: rtl/vga_fx_pkg.sv
// Shared definitions for the VGA effect pipeline.
//   - effect select codes (FX_*)
//   - default 640x480 timing constants
//   - sync_t: raw/delayed sync+blank bundle carried down the delay line
//   - to8/from8: widen a colour channel to 8 bits (left-aligned) and back
//   - sat_add8: 8-bit add clamped at 255
package vga_fx_pkg;

   localparam logic [2:0] FX_PASS   = 3'd0;
   localparam logic [2:0] FX_INV    = 3'd1;
   localparam logic [2:0] FX_GRAY   = 3'd2;
   localparam logic [2:0] FX_RED    = 3'd3;
   localparam logic [2:0] FX_GREEN  = 3'd4;
   localparam logic [2:0] FX_BLUE   = 3'd5;
   localparam logic [2:0] FX_THRESH = 3'd6;
   localparam logic [2:0] FX_SWAP   = 3'd7;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank;
   } sync_t;

   // v holds a w-bit channel in its low bits; result is left-aligned, zero-filled.
   function automatic logic [7:0] to8(input logic [7:0] v, input int w);
      logic [15:0] t;
      t = {8'd0, v} << (8 - w);
      return t[7:0];
   endfunction

   // Keeps the top w bits of c, returned in the low bits.
   function automatic logic [7:0] from8(input logic [7:0] c, input int w);
      return c >> (8 - w);
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] inc);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, inc};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/vga_fx_pipeline_timing.sv
// vga_timing_gen: free-running VGA raster counters.
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   hc, vc            horizontal/vertical position (also frame-buffer address)
//   active            hc/vc inside the visible region
//   hsync, vsync      raw (undelayed) sync at SYNC_POL level inside the pulse
//   frame_start       high while hc==0 && vc==0
module vga_timing_gen
   import vga_fx_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] hc,
   output logic [CW-1:0] vc,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   assign active      = (hc < H_VIS) && (vc < V_VIS);
   assign hsync       = (hc >= HS_BEG && hc < HS_END) ? SYNC_POL : ~SYNC_POL;
   assign vsync       = (vc >= VS_BEG && vc < VS_END) ? SYNC_POL : ~SYNC_POL;
   assign frame_start = (hc == '0) && (vc == '0);

endmodule

// File: rtl/vga_fx_pipeline.sv
// vga_fx_pipeline: VGA timing plus a per-pixel colour effect stage.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   choice, b           effect select / brightness, latched at frame start
//   pix_data            {R,G,B} for the hc/vc issued MEM_LAT cycles earlier
//   hc, vc              raw counters (frame-buffer read address)
//   hsync, vsync, blank sync/blank delayed MEM_LAT+1 cycles to line up with colour
//   red, green, blue    effect + brightness result, 0 while blank
//   frame_start         undelayed pulse at (0,0)
module vga_fx_pipeline
   import vga_fx_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0,
   parameter int   RW       = 3,
   parameter int   GW       = 3,
   parameter int   BW       = 2,
   parameter int   CW       = 10,
   parameter int   MEM_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         choice,
   input  logic [1:0]         b,
   input  logic [RW+GW+BW-1:0] pix_data,
   output logic [CW-1:0]      hc,
   output logic [CW-1:0]      vc,
   output logic               hsync,
   output logic               vsync,
   output logic               blank,
   output logic [RW-1:0]      red,
   output logic [GW-1:0]      green,
   output logic [BW-1:0]      blue,
   output logic               frame_start
);

   localparam int    PW   = RW + GW + BW;
   localparam int    L    = MEM_LAT + 1;
   localparam sync_t IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, blank: 1'b1};

   logic  act_raw, hs_raw, vs_raw;
   sync_t raw;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL), .CW(CW)
   ) u_timing (
      .clk(clk), .rst(rst), .hc(hc), .vc(vc), .active(act_raw),
      .hsync(hs_raw), .vsync(vs_raw), .frame_start(frame_start)
   );

   assign raw = '{hsync: hs_raw, vsync: vs_raw, blank: ~act_raw};

   // tap[k] = sync/blank of the pixel addressed k cycles ago; tap[0] is live.
   sync_t [L:1] pipe_q;
   sync_t [L:0] tap;
   assign tap = {pipe_q, raw};

   always_ff @(posedge clk) begin
      if (rst) pipe_q <= {L{IDLE}};
      else     pipe_q <= tap[L-1:0];
   end

   assign hsync = tap[L].hsync;
   assign vsync = tap[L].vsync;
   assign blank = tap[L].blank;

   // Frame-synchronous selects.
   logic [2:0] sel_q;
   logic [1:0] bri_q;
   logic [2:0] sel_use;
   logic [1:0] bri_use;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
         bri_q <= '0;
      end else if (frame_start) begin
         sel_q <= choice;
         bri_q <= b;
      end
   end

   // With no memory latency the (0,0) pixel is processed in the same cycle
   // it is latched, so bypass the shadow register for it.
   assign sel_use = (MEM_LAT == 0 && frame_start) ? choice : sel_q;
   assign bri_use = (MEM_LAT == 0 && frame_start) ? b      : bri_q;

   // Effect + brightness datapath.
   logic [7:0] r8, g8, b8, y, er, eg, eb, inc, rs, gs, bs, rn, gn, bn;
   logic [9:0] y10;

   always_comb begin
      r8  = to8(8'(pix_data[PW-1 -: RW]), RW);
      g8  = to8(8'(pix_data[GW+BW-1 -: GW]), GW);
      b8  = to8(8'(pix_data[BW-1:0]), BW);
      y10 = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
      y   = y10[9:2];
      er  = r8;
      eg  = g8;
      eb  = b8;
      case (sel_use)
         FX_INV:    begin er = ~r8;   eg = ~g8;   eb = ~b8;   end
         FX_GRAY:   begin er = y;     eg = y;     eb = y;     end
         FX_RED:    begin             eg = '0;    eb = '0;    end
         FX_GREEN:  begin er = '0;                eb = '0;    end
         FX_BLUE:   begin er = '0;    eg = '0;                end
         FX_THRESH: begin
            er = {8{y[7]}};
            eg = {8{y[7]}};
            eb = {8{y[7]}};
         end
         FX_SWAP:   begin er = g8;    eg = b8;    eb = r8;    end
         default:   ;
      endcase
      inc = {bri_use, 6'd0};
      rs  = sat_add8(er, inc);
      gs  = sat_add8(eg, inc);
      bs  = sat_add8(eb, inc);
      rn  = from8(rs, RW);
      gn  = from8(gs, GW);
      bn  = from8(bs, BW);
   end

   // Pixel data arriving now belongs to tap[MEM_LAT]; its blank gates colour.
   always_ff @(posedge clk) begin
      if (rst || tap[MEM_LAT].blank) begin
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         red   <= rn[RW-1:0];
         green <= gn[GW-1:0];
         blue  <= bn[BW-1:0];
      end
   end

endmodule
